cursor_ctrl: RTL
================

// Module: cursor_ctrl
// PURPOSE
//   Parametrised cursor/selection controller for the elimination-game board.
//   - Accepts decoded player operations over a valid/ready handshake.
//   - Moves the cursor on a GRID_W x GRID_H grid and tracks select/cancel state.
//   - Issues a held elimination request, with latched coordinates, to the board engine and waits for its ack.
//   - Sits between the key decoder and the board/elimination logic.
// PARAMETERS
//   GRID_W   8    grid columns; x range 0..GRID_W-1
//   GRID_H   8    grid rows; y range 0..GRID_H-1
//   XW       4    x coordinate width; must be >= clog2(GRID_W)
//   YW       4    y coordinate width; must be >= clog2(GRID_H)
//   CNTW     16   width of the move counter
// PORTS
//   clk        in   1     system clock; all state updates on posedge
//   rst_n      in   1     asynchronous active-low reset
//   op_valid   in   1     op is presented this cycle
//   op         in   3     0 NOP, 1 SELECT, 2 CANCEL, 3 LEFT, 4 RIGHT, 5 UP, 6 DOWN, 7 reserved
//   op_ready   out  1     controller can accept an op (combinational from state)
//   cur_x      out  XW    cursor column
//   cur_y      out  YW    cursor row
//   selected   out  1     a cell is selected
//   elim_req   out  1     elimination request, held until acked
//   elim_x     out  XW    column latched at elimination request
//   elim_y     out  YW    row latched at elimination request
//   elim_ack   in   1     board engine has consumed elim_req
//   op_err     out  1     1-cycle pulse: accepted op was rejected
//   move_cnt   out  CNTW  saturating count of cursor moves that changed position
// BEHAVIOUR
//   Reset (async, rst_n=0), all outputs:
//   - state=IDLE, cur_x=0, cur_y=0, selected=0, elim_req=0, elim_x=0, elim_y=0, op_err=0, move_cnt=0.
//   - op_ready=1. Reset mid-ELIM drops elim_req immediately; no ack is awaited.
//   Handshake:
//   - Op accepted when op_valid & op_ready at posedge.
//   - Result is visible the next cycle (1-cycle latency). At most one op per cycle.
//   FSM (op_ready = state!=ELIM):
//   - IDLE:
//     - SELECT -> SEL, selected=1.
//     - LEFT/RIGHT/UP/DOWN: move the cursor.
//     - CANCEL and NOP: no effect.
//   - SEL:
//     - SELECT -> ELIM: elim_req=1, elim_x/elim_y <= cur_x/cur_y.
//     - CANCEL -> IDLE, selected=0.
//     - Moves: cursor frozen, op_err pulses.
//   - ELIM:
//     - Ops are not accepted.
//     - On posedge with elim_ack=1: -> IDLE, elim_req=0, selected=0. Cursor is unchanged.
//   - elim_ack is ignored in IDLE and SEL.
//   - Op 7 in any accepting state: no state change, op_err pulses.
//   - NOP never sets op_err.
//   Moves:
//   - LEFT: x-1. RIGHT: x+1. UP: y-1. DOWN: y+1. Arithmetic is in XW/YW bits.
//   - Bound compare is against GRID_W-1 / GRID_H-1.
//   - At an edge without wrap: the position is held, op_err=0 and move_cnt is not incremented.
//   - move_cnt increments only when cur_x or cur_y actually changes. It saturates at all-ones.
// CONFIGURATION
//   CURSOR_WRAP_EN defined:
//   - Moves past an edge wrap: LEFT at x=0 -> GRID_W-1; RIGHT at GRID_W-1 -> 0; UP at y=0 -> GRID_H-1; DOWN at GRID_H-1 -> 0.
//   - A wrap counts as a move.
//   CURSOR_WRAP_EN undefined:
//   - Cursor clamps at the edges, as described in BEHAVIOUR.
// TESTING
//   1. Reset, then RIGHT x3, DOWN x2 -> cur=(3,2), move_cnt=5, selected=0, op_err never set.
//   2. At (0,0): LEFT, UP.
//      - No wrap: cur stays (0,0), move_cnt unchanged.
//      - CURSOR_WRAP_EN: cur=(7,7) after both ops, move_cnt=+2.
//   3. At (3,2): SELECT, then RIGHT.
//      - After SELECT: selected=1.
//      - After RIGHT: op_err pulses 1 cycle, cur stays (3,2).
//      - Then CANCEL -> selected=0.
//   4. At (3,2): SELECT, SELECT.
//      - elim_req=1 with elim=(3,2), op_ready=0.
//      - Hold elim_ack=0 for 4 cycles: elim_req stays 1.
//      - Pulse elim_ack: next cycle elim_req=0, selected=0, op_ready=1.
//   5. Drive op_valid with DOWN during ELIM: op not accepted, cur_y unchanged.
//      Drive elim_ack=1 in IDLE: no effect.
//   6. Assert rst_n=0 mid-ELIM, asynchronously between edges:
//      - elim_req=0 and cur=(0,0) before the next edge.
//      - move_cnt=0.
//      - op 7 after reset -> op_err pulse only.

Source files
------------

// File: rtl/cursor_ctrl.sv
// Cursor/selection controller between the key decoder and the board engine.
// Optional feature: define CURSOR_WRAP_EN to wrap the cursor at grid edges.
module cursor_ctrl #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op,
  output logic            op_ready,
  output logic [XW-1:0]   cur_x,
  output logic [YW-1:0]   cur_y,
  output logic            selected,
  output logic            elim_req,
  output logic [XW-1:0]   elim_x,
  output logic [YW-1:0]   elim_y,
  input  logic            elim_ack,
  output logic            op_err,
  output logic [CNTW-1:0] move_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] ELIM = 2'd2;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SELECT = 3'd1;
  localparam logic [2:0] OP_CANCEL = 3'd2;
  localparam logic [2:0] OP_LEFT   = 3'd3;
  localparam logic [2:0] OP_RIGHT  = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  logic [1:0]    state;
  logic          accept;
  logic          is_move;
  logic          moved;
  logic [XW-1:0] mv_x;
  logic [YW-1:0] mv_y;

  assign op_ready = (state != ELIM);
  assign accept   = op_valid & op_ready;

  assign is_move = (op == OP_LEFT) || (op == OP_RIGHT) ||
                   (op == OP_UP)   || (op == OP_DOWN);

  // Candidate position for a move op; equals the current one when clamped.
  always_comb begin
    mv_x = cur_x;
    mv_y = cur_y;
    case (op)
      OP_LEFT: begin
        if (cur_x != '0) mv_x = cur_x - 1'b1;
`ifdef CURSOR_WRAP_EN
        else             mv_x = X_MAX;
`endif
      end
      OP_RIGHT: begin
        if (cur_x < X_MAX) mv_x = cur_x + 1'b1;
`ifdef CURSOR_WRAP_EN
        else               mv_x = '0;
`endif
      end
      OP_UP: begin
        if (cur_y != '0) mv_y = cur_y - 1'b1;
`ifdef CURSOR_WRAP_EN
        else             mv_y = Y_MAX;
`endif
      end
      OP_DOWN: begin
        if (cur_y < Y_MAX) mv_y = cur_y + 1'b1;
`ifdef CURSOR_WRAP_EN
        else               mv_y = '0;
`endif
      end
      default: begin
        mv_x = cur_x;
        mv_y = cur_y;
      end
    endcase
  end

  assign moved = is_move && ((mv_x != cur_x) || (mv_y != cur_y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      selected <= 1'b0;
      elim_req <= 1'b0;
      elim_x   <= '0;
      elim_y   <= '0;
      op_err   <= 1'b0;
      move_cnt <= '0;
    end else begin
      op_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_SELECT: begin
                state    <= SEL;
                selected <= 1'b1;
              end
              OP_LEFT, OP_RIGHT, OP_UP, OP_DOWN: begin
                cur_x <= mv_x;
                cur_y <= mv_y;
                if (moved && (move_cnt != '1))
                  move_cnt <= move_cnt + 1'b1;
              end
              OP_RSVD: op_err <= 1'b1;
              default: ;
            endcase
          end
        end
        SEL: begin
          if (accept) begin
            case (op)
              OP_SELECT: begin
                state    <= ELIM;
                elim_req <= 1'b1;
                elim_x   <= cur_x;
                elim_y   <= cur_y;
              end
              OP_CANCEL: begin
                state    <= IDLE;
                selected <= 1'b0;
              end
              OP_LEFT, OP_RIGHT, OP_UP, OP_DOWN,
              OP_RSVD: op_err <= 1'b1;
              default: ;
            endcase
          end
        end
        ELIM: begin
          if (elim_ack) begin
            state    <= IDLE;
            elim_req <= 1'b0;
            selected <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
